// File: rtl/sc_strobe_responder.sv
// Strobe responder: accepts active-low clear/load strobes, acknowledges, then holds busy for HOLD_CYCLES.
// Latency: outputs update one edge after the strobe; strobes arriving while busy are dropped and flag overrun.
module sc_strobe_responder #(
    parameter int DATAWIDTH_BUS = 8,
    parameter int HOLD_CYCLES   = 4
) (
    input  logic                     SC_STATEMACHINE_CLOCK_50,
    input  logic                     SC_STATEMACHINE_RESET_InHigh,
    input  logic                     SC_STROBE_RESPONDER_clear_InLow,
    input  logic                     SC_STROBE_RESPONDER_load_InLow,
    input  logic [DATAWIDTH_BUS-1:0] SC_STROBE_RESPONDER_data_InBUS,
    output logic [DATAWIDTH_BUS-1:0] SC_STROBE_RESPONDER_data_OutBUS,
    output logic [7:0]               SC_STROBE_RESPONDER_loadcount_OutBUS,
    output logic                     SC_STROBE_RESPONDER_ack_OutLow,
    output logic                     SC_STROBE_RESPONDER_busy_OutHigh,
    output logic                     SC_STROBE_RESPONDER_overrun_OutHigh
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        ACK   = 3'd3,
        HOLD  = 3'd4
    } state_t;

    localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES);

    state_t                   state;
    logic [DATAWIDTH_BUS-1:0] stagingData;
    logic [3:0]               holdCount;
    logic                     strobeSeen;

    assign strobeSeen = !SC_STROBE_RESPONDER_clear_InLow || !SC_STROBE_RESPONDER_load_InLow;

    // ack/busy are registered alongside the state so they always equal a decode of it.
    always_ff @(posedge SC_STATEMACHINE_CLOCK_50 or posedge SC_STATEMACHINE_RESET_InHigh) begin
        if (SC_STATEMACHINE_RESET_InHigh) begin
            state                                <= IDLE;
            stagingData                          <= '0;
            holdCount                            <= '0;
            SC_STROBE_RESPONDER_data_OutBUS      <= '0;
            SC_STROBE_RESPONDER_loadcount_OutBUS <= '0;
            SC_STROBE_RESPONDER_ack_OutLow       <= 1'b1;
            SC_STROBE_RESPONDER_busy_OutHigh     <= 1'b0;
            SC_STROBE_RESPONDER_overrun_OutHigh  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!SC_STROBE_RESPONDER_clear_InLow) begin
                        state                            <= CLEAR;
                        SC_STROBE_RESPONDER_busy_OutHigh <= 1'b1;
                        // A load arriving with the clear is dropped; CLEAR exit wipes the flag again.
                        if (!SC_STROBE_RESPONDER_load_InLow)
                            SC_STROBE_RESPONDER_overrun_OutHigh <= 1'b1;
                    end else if (!SC_STROBE_RESPONDER_load_InLow) begin
                        state                            <= LOAD;
                        stagingData                      <= SC_STROBE_RESPONDER_data_InBUS;
                        SC_STROBE_RESPONDER_busy_OutHigh <= 1'b1;
                    end
                end
                CLEAR: begin
                    state                                <= ACK;
                    SC_STROBE_RESPONDER_ack_OutLow       <= 1'b0;
                    SC_STROBE_RESPONDER_data_OutBUS      <= '0;
                    SC_STROBE_RESPONDER_loadcount_OutBUS <= '0;
                    SC_STROBE_RESPONDER_overrun_OutHigh  <= strobeSeen;
                end
                LOAD: begin
                    state                                <= ACK;
                    SC_STROBE_RESPONDER_ack_OutLow       <= 1'b0;
                    SC_STROBE_RESPONDER_data_OutBUS      <= stagingData;
                    SC_STROBE_RESPONDER_loadcount_OutBUS <= SC_STROBE_RESPONDER_loadcount_OutBUS + 8'd1;
                    if (strobeSeen)
                        SC_STROBE_RESPONDER_overrun_OutHigh <= 1'b1;
                end
                ACK: begin
                    SC_STROBE_RESPONDER_ack_OutLow <= 1'b1;
                    if (strobeSeen)
                        SC_STROBE_RESPONDER_overrun_OutHigh <= 1'b1;
                    if (HOLD_INIT != 4'd0) begin
                        state     <= HOLD;
                        holdCount <= HOLD_INIT;
                    end else begin
                        state                            <= IDLE;
                        SC_STROBE_RESPONDER_busy_OutHigh <= 1'b0;
                    end
                end
                HOLD: begin
                    if (strobeSeen)
                        SC_STROBE_RESPONDER_overrun_OutHigh <= 1'b1;
                    if (holdCount <= 4'd1) begin
                        state                            <= IDLE;
                        holdCount                        <= '0;
                        SC_STROBE_RESPONDER_busy_OutHigh <= 1'b0;
                    end else begin
                        holdCount <= holdCount - 4'd1;
                    end
                end
                default: begin
                    state                            <= IDLE;
                    holdCount                        <= '0;
                    SC_STROBE_RESPONDER_ack_OutLow   <= 1'b1;
                    SC_STROBE_RESPONDER_busy_OutHigh <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_strobe_responder.sv
// Bench for sc_strobe_responder: cycle vector table, load-count wrap, and reset-abort sequences.
module tb_sc_strobe_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clrN = 1'b1;
    logic       ldN = 1'b1;
    logic [7:0] din = 8'h00;
    logic [7:0] dataOut;
    logic [7:0] cntOut;
    logic       ackOut;
    logic       busyOut;
    logic       ovrOut;

    always #5 clk = ~clk;

    sc_strobe_responder #(.DATAWIDTH_BUS(8), .HOLD_CYCLES(4)) dut (
        .SC_STATEMACHINE_CLOCK_50            (clk),
        .SC_STATEMACHINE_RESET_InHigh        (rst),
        .SC_STROBE_RESPONDER_clear_InLow     (clrN),
        .SC_STROBE_RESPONDER_load_InLow      (ldN),
        .SC_STROBE_RESPONDER_data_InBUS      (din),
        .SC_STROBE_RESPONDER_data_OutBUS     (dataOut),
        .SC_STROBE_RESPONDER_loadcount_OutBUS(cntOut),
        .SC_STROBE_RESPONDER_ack_OutLow      (ackOut),
        .SC_STROBE_RESPONDER_busy_OutHigh    (busyOut),
        .SC_STROBE_RESPONDER_overrun_OutHigh (ovrOut)
    );

    typedef struct {
        logic       clrN;
        logic       ldN;
        logic [7:0] din;
        logic [7:0] eData;
        logic [7:0] eCnt;
        logic       eAck;
        logic       eBusy;
        logic       eOvr;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [7:0] cnt;
        logic       ack;
        logic       busy;
        logic       ovr;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   passCount = 0;
    int   checkCount = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checkCount++;
        if (act === req) passCount++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    endtask

    task automatic checkAll(input string tag, input exp_t e);
        chk({tag, ".data"}, 32'(dataOut), 32'(e.data));
        chk({tag, ".cnt"},  32'(cntOut),  32'(e.cnt));
        chk({tag, ".ack"},  32'(ackOut),  32'(e.ack));
        chk({tag, ".busy"}, 32'(busyOut), 32'(e.busy));
        chk({tag, ".ovr"},  32'(ovrOut),  32'(e.ovr));
    endtask

    task automatic add(input logic c, input logic l, input logic [7:0] d, input logic [7:0] ed,
                       input logic [7:0] ec, input logic ea, input logic eb, input logic eo);
        vec_t v;
        v = '{c, l, d, ed, ec, ea, eb, eo};
        vecs.push_back(v);
    endtask

    task automatic addHold(input int n, input logic [7:0] d, input logic [7:0] c, input logic o);
        for (int k = 0; k < n; k++) add(1'b1, 1'b1, 8'h00, d, c, 1'b1, 1'b1, o);
    endtask

    task automatic addIdle(input logic [7:0] d, input logic [7:0] c, input logic o);
        add(1'b1, 1'b1, 8'h00, d, c, 1'b1, 1'b0, o);
    endtask

    task automatic step(input logic c, input logic l, input logic [7:0] d);
        @(negedge clk);
        clrN = c;
        ldN  = l;
        din  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while (busyOut !== 1'b0 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, ".idle"}, 32'(busyOut), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL global timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        exp_t rstExp;
        int   n;
        rstExp = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0};

        #12;
        checkAll("reset", rstExp);
        @(negedge clk);
        rst = 1'b0;

        // Single load of A5: busy for LOAD, ACK and four HOLD cycles.
        add(1, 0, 8'hA5, 8'h00, 8'd0, 1, 1, 0);
        add(1, 1, 8'h00, 8'hA5, 8'd1, 0, 1, 0);
        addHold(4, 8'hA5, 8'd1, 0);
        addIdle(8'hA5, 8'd1, 0);
        // Second load two cycles after the first is dropped and sets overrun.
        add(1, 0, 8'h11, 8'hA5, 8'd1, 1, 1, 0);
        add(1, 1, 8'h00, 8'h11, 8'd2, 0, 1, 0);
        add(1, 0, 8'h22, 8'h11, 8'd2, 1, 1, 1);
        addHold(3, 8'h11, 8'd2, 1);
        addIdle(8'h11, 8'd2, 1);
        // Clear and load together: clear wins, overrun wiped on CLEAR exit.
        add(0, 0, 8'h33, 8'h11, 8'd2, 1, 1, 1);
        add(1, 1, 8'h00, 8'h00, 8'd0, 0, 1, 0);
        addHold(4, 8'h00, 8'd0, 0);
        addIdle(8'h00, 8'd0, 0);
        // Load 3C then clear.
        add(1, 0, 8'h3C, 8'h00, 8'd0, 1, 1, 0);
        add(1, 1, 8'h00, 8'h3C, 8'd1, 0, 1, 0);
        addHold(4, 8'h3C, 8'd1, 0);
        addIdle(8'h3C, 8'd1, 0);
        add(0, 1, 8'h00, 8'h3C, 8'd1, 1, 1, 0);
        add(1, 1, 8'h00, 8'h00, 8'd0, 0, 1, 0);
        addHold(4, 8'h00, 8'd0, 0);
        addIdle(8'h00, 8'd0, 0);
        // Load held low two cycles: one accept plus overrun; staging keeps first data.
        add(1, 0, 8'h44, 8'h00, 8'd0, 1, 1, 0);
        add(1, 0, 8'h45, 8'h44, 8'd1, 0, 1, 1);
        addHold(4, 8'h44, 8'd1, 1);
        addIdle(8'h44, 8'd1, 1);
        // Drop on the CLEAR exit edge leaves overrun set; a clean clear then wipes it.
        add(0, 1, 8'h00, 8'h44, 8'd1, 1, 1, 1);
        add(1, 0, 8'h00, 8'h00, 8'd0, 0, 1, 1);
        addHold(4, 8'h00, 8'd0, 1);
        addIdle(8'h00, 8'd0, 1);
        add(0, 1, 8'h00, 8'h00, 8'd0, 1, 1, 1);
        add(1, 1, 8'h00, 8'h00, 8'd0, 0, 1, 0);
        addHold(4, 8'h00, 8'd0, 0);
        addIdle(8'h00, 8'd0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            sb.push_back('{vecs[i].eData, vecs[i].eCnt, vecs[i].eAck, vecs[i].eBusy, vecs[i].eOvr});
            step(vecs[i].clrN, vecs[i].ldN, vecs[i].din);
            e = sb.pop_front();
            checkAll($sformatf("vec%0d", i), e);
        end

        // Load count wraps modulo 256 after reset.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 257; i++) begin
            @(negedge clk);
            ldN = 1'b0;
            din = 8'(i * 7 + 3);
            sb.push_back('{8'(i * 7 + 3), 8'((i + 1) % 256), 1'b0, 1'b1, 1'b0});
            @(negedge clk);
            ldN = 1'b1;
            n = 0;
            while (ackOut !== 1'b0 && n < 6) begin
                @(posedge clk);
                #1;
                n++;
            end
            e = sb.pop_front();
            chk($sformatf("wrap%0d.ack", i), 32'(ackOut), 32'(e.ack));
            chk($sformatf("wrap%0d.cnt", i), 32'(cntOut), 32'(e.cnt));
            if (i >= 255) chk($sformatf("wrap%0d.data", i), 32'(dataOut), 32'(e.data));
            waitIdle($sformatf("wrap%0d", i));
        end

        // Reset during HOLD aborts with outputs at reset values immediately.
        step(1, 0, 8'h77);
        step(1, 1, 8'h00);
        @(posedge clk);
        #1;
        chk("rstHold.preBusy", 32'(busyOut), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkAll("rstHold", rstExp);
        @(posedge clk);
        #1;
        checkAll("rstHoldEdge", rstExp);
        @(negedge clk);
        rst = 1'b0;

        // Reset during LOAD: no count increment, no data update, no ack.
        step(1, 0, 8'h12);
        step(1, 1, 8'h00);
        waitIdle("preLoad");
        chk("preLoad.cnt", 32'(cntOut), 32'd1);
        step(1, 0, 8'h34);
        @(negedge clk);
        ldN = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checkAll("rstLoad", rstExp);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rstLoadHeld%0d.ack", k), 32'(ackOut), 32'd1);
        end
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 8'h99);
        step(1, 1, 8'h00);
        checkAll("postRst", '{8'h99, 8'd1, 1'b0, 1'b1, 1'b0});

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/sc_strobe_responder.md
SC_STROBE_RESPONDER -- requirements
Module: sc_strobe_responder

Interface
REQ-001 Parameter DATAWIDTH_BUS, default 8: width of the data input and held-data output.
REQ-002 Parameter HOLD_CYCLES, default 4, legal range 0..15: busy-hold length after acknowledge.
REQ-003 SC_STATEMACHINE_CLOCK_50  input  1  system clock; all state changes on rising edge.
REQ-004 SC_STATEMACHINE_RESET_InHigh  input  1  reset, asynchronous, active-high.
REQ-005 SC_STROBE_RESPONDER_clear_InLow  input  1  single-cycle active-low clear strobe from the command state machine.
REQ-006 SC_STROBE_RESPONDER_load_InLow  input  1  single-cycle active-low load strobe from the command state machine.
REQ-007 SC_STROBE_RESPONDER_data_InBUS  input  DATAWIDTH_BUS  data to capture on load.
REQ-008 SC_STROBE_RESPONDER_data_OutBUS  output  DATAWIDTH_BUS  held data register.
REQ-009 SC_STROBE_RESPONDER_loadcount_OutBUS  output  8  number of accepted loads since last clear/reset.
REQ-010 SC_STROBE_RESPONDER_ack_OutLow  output  1  single-cycle active-low acknowledge of an accepted strobe.
REQ-011 SC_STROBE_RESPONDER_busy_OutHigh  output  1  high while a command is in progress.
REQ-012 SC_STROBE_RESPONDER_overrun_OutHigh  output  1  sticky flag: a strobe was dropped.

Function
REQ-013 The block SHALL implement a Moore FSM with states IDLE, CLEAR, LOAD, ACK, HOLD; outputs decode from state register only (registered data/count/flag excepted).
REQ-014 IDLE: strobes sampled at each rising edge; clear_InLow=0 -> CLEAR; else load_InLow=0 -> LOAD; else stay IDLE.
REQ-015 On the edge accepting a load, data_InBUS SHALL be captured into a staging register.
REQ-016 CLEAR lasts exactly one cycle; on its exit edge data_OutBUS <= 0, loadcount_OutBUS <= 0, overrun_OutHigh <= 0; next state ACK.
REQ-017 LOAD lasts exactly one cycle; on its exit edge data_OutBUS <= staging value, loadcount_OutBUS <= loadcount_OutBUS + 1 modulo 256 (255 -> 0, no saturation); next state ACK.
REQ-018 ACK lasts exactly one cycle with ack_OutLow=0; next state HOLD if HOLD_CYCLES>0, else IDLE.
REQ-019 HOLD lasts exactly HOLD_CYCLES cycles (4-bit down-counter loaded on ACK exit), then IDLE.
REQ-020 busy_OutHigh SHALL be 1 in CLEAR, LOAD, ACK, HOLD and 0 in IDLE; ack_OutLow SHALL be 1 in every state except ACK.
REQ-021 Latency: strobe sampled at edge N -> data_OutBUS/loadcount updated at edge N+1, ack low during cycle N+1..N+2, IDLE reached at edge N+2+HOLD_CYCLES.
REQ-022 Any strobe (clear or load) sampled low while not in IDLE SHALL be ignored and SHALL set overrun_OutHigh at that edge.
REQ-023 Simultaneous clear and load low in IDLE: clear accepted, load dropped, overrun_OutHigh set at the same edge then cleared again by CLEAR exit (clear has final effect).
REQ-024 overrun_OutHigh SHALL be cleared only by reset or CLEAR exit; a drop in the same edge as CLEAR exit leaves it set.
REQ-025 Strobe held low across several cycles SHALL be treated as one accepted strobe plus overrun for each additional low cycle sampled while busy.
REQ-026 Undefined state encodings SHALL return to IDLE on the next edge with outputs at IDLE values.

Reset
REQ-027 Reset assertion SHALL force, asynchronously and regardless of clock: state IDLE, data_OutBUS=0, staging=0, loadcount_OutBUS=0, hold counter=0, ack_OutLow=1, busy_OutHigh=0, overrun_OutHigh=0.
REQ-028 Reset asserted mid-command SHALL abort it with no ack pulse and no register update; first strobe sampled after deassertion is accepted normally.

Verification
REQ-029 Reset, then load strobe with data_InBUS=8'hA5 at edge N -> data_OutBUS=8'hA5 and loadcount=1 after edge N+1, ack low one cycle, busy high 6 cycles (HOLD_CYCLES=4).
REQ-030 256 isolated loads after reset -> loadcount_OutBUS wraps to 0; 257th load -> 1.
REQ-031 Load 8'h3C, then clear strobe -> data_OutBUS=0, loadcount=0, overrun=0, one ack pulse per strobe.
REQ-032 Load strobe, second load strobe 2 cycles later (busy) -> second ignored, data_OutBUS keeps first value, overrun=1 until next clear.
REQ-033 Clear and load low in same IDLE cycle -> CLEAR path taken, data_OutBUS=0, overrun=0 after CLEAR exit.
REQ-034 Reset pulsed during HOLD and separately during LOAD -> outputs at reset values immediately, no ack, no data/count change.
